main_fsm_controller: RTL

//  Multicycle main control FSM for the RISC-V core. Sequences the shared ALU, PC,

---
 rtl/main_fsm_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/main_fsm_controller.sv
// Multicycle main control FSM: sequences fetch/decode/execute over a shared ALU and
// unified memory, stalling memory states on the mem_ready handshake.
module main_fsm_controller #(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter bit WAIT_MEM     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StIllegal  = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  state_e state_q, state_d;
  logic   rdy;
  logic   pc_update, branch;
  logic   mem_write_raw, ir_write_raw, reg_write_raw;

  assign rdy   = WAIT_MEM ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (rdy) state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = ILLEGAL_HALT ? StIllegal : StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (rdy) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (rdy) state_d = StFetch;
      StExecR,
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal       = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    unique case (state_q)
      StFetch: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = rdy;
        pc_update    = rdy;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      StMemWrite: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWb:    reg_write_raw = 1'b1;
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      StIllegal:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Enables are gated by reset so nothing commits while reset is held low.
  assign pc_write  = reset & (pc_update | (branch & zero));
  assign mem_write = reset & mem_write_raw;
  assign ir_write  = reset & ir_write_raw;
  assign reg_write = reset & reg_write_raw;

endmodule
